// File: rtl/mips_pkg.sv
// mips_pkg: redirect type codes, default reset PC and fetch FSM encoding.
// ERR exists only when IFU_ALIGN_CHECK_EN is defined.
package mips_pkg;
  localparam logic [1:0] RT_BRANCH = 2'b00;
  localparam logic [1:0] RT_JUMP   = 2'b01;
  localparam logic [1:0] RT_JR     = 2'b10;
  localparam logic [1:0] RT_RSVD   = 2'b11;
  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
`ifdef IFU_ALIGN_CHECK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2, ERR = 2'd3} fetch_state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, DONE = 2'd2} fetch_state_t;
`endif
endpackage

// File: rtl/npc_calc.sv
// npc_calc: next-PC selection from sequential, branch, j/jal and jr redirects.
module npc_calc import mips_pkg::*; (
  input  logic [31:0] pc,
  input  logic        redirect_valid,
  input  logic [1:0]  redirect_type,
  input  logic        branch_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] rs_val,
  output logic [31:0] npc
);
  logic [31:0] seq, br;
  always_comb begin
    seq = pc + 32'd4;
    br  = seq + {{14{imm16[15]}}, imm16, 2'b00};
    npc = !redirect_valid              ? seq :
          redirect_type == RT_BRANCH   ? (branch_taken ? br : seq) :
          redirect_type == RT_JUMP     ? {pc[31:28], imm26, 2'b00} :
          redirect_type == RT_JR       ? rs_val : seq;
  end
endmodule

// File: rtl/ifu_fetch_ctrl.sv
// ifu_fetch_ctrl: PC owner issuing req/ack word fetches to the IM and holding instr for decode.
// IFU_ALIGN_CHECK_EN: trap misaligned next-PC into a sticky ERR state with fetch_exc.
module ifu_fetch_ctrl import mips_pkg::*; #(
  parameter logic [31:0] RESET_PC   = DEF_RESET_PC,
  parameter int unsigned WAIT_LIMIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [1:0]  redirect_type,
  input  logic        branch_taken,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] rs_val,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_instr,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        im_timeout
`ifdef IFU_ALIGN_CHECK_EN
  , output logic      fetch_exc
`endif
);
  localparam logic [31:0] WL = 32'(WAIT_LIMIT);
  fetch_state_t state, state_nxt;
  logic [31:0] npc_raw, npc, cnt;
  logic drop, ack_ok, expire, advance, misalign;

  npc_calc u_npc (
    .pc(pc), .redirect_valid(redirect_valid), .redirect_type(redirect_type),
    .branch_taken(branch_taken), .imm16(imm16), .imm26(imm26), .rs_val(rs_val),
    .npc(npc_raw)
  );

`ifdef IFU_ALIGN_CHECK_EN
  assign misalign = npc_raw[1:0] != 2'b00;
  assign npc      = npc_raw;
`else
  assign misalign = 1'b0;
  assign npc      = {npc_raw[31:2], 2'b00};
`endif

  // drop marks the one idle cycle inserted after a wait-limit expiry
  assign ack_ok  = state == REQ && !drop && im_ack;
  assign expire  = state == REQ && !drop && !im_ack && WAIT_LIMIT != 0 && cnt + 32'd1 == WL;
  assign advance = state == DONE && !stall;

  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = REQ;
      REQ:     state_nxt = ack_ok ? DONE : REQ;
`ifdef IFU_ALIGN_CHECK_EN
      DONE:    state_nxt = advance ? (misalign ? ERR : REQ) : DONE;
`else
      DONE:    state_nxt = advance ? REQ : DONE;
`endif
      default: state_nxt = state;
    endcase
  end

  always_comb begin
    im_req      = state == REQ && !drop;
    instr_valid = state == DONE;
    im_addr     = pc;
    pc_plus4    = pc + 32'd4;
  end

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc         <= RESET_PC;
      instr      <= 32'd0;
      cnt        <= 32'd0;
      drop       <= 1'b0;
      im_timeout <= 1'b0;
    end else begin
      drop       <= expire;
      im_timeout <= expire;
      cnt        <= (state != REQ || drop || im_ack || expire) ? 32'd0 : cnt + 32'd1;
      if (ack_ok) instr <= im_instr;
      if (advance && !misalign) pc <= npc;
    end

`ifdef IFU_ALIGN_CHECK_EN
  always_ff @(posedge clk or posedge reset)
    if (reset) fetch_exc <= 1'b0;
    else if (advance && misalign) fetch_exc <= 1'b1;
`endif
endmodule

// File: doc/ifu_fetch_ctrl.md
Name: ifu_fetch_ctrl

Overview:
Fetch-side initiator that owns the program counter and drives addresses into the instruction memory. It issues word fetches over a req/ack handshake and holds the fetched instruction for decode under stall. It computes the next PC from sequential, branch, j/jal and jr redirect inputs. It sits in the IFU ahead of the IM, which is the responder that returns instruction words.

Parameters:
RESET_PC, 32'h0000_3000, PC value loaded on reset; first fetch address.
WAIT_LIMIT, 0, max cycles im_req may stay unacknowledged before a retry; 0 = wait forever.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
stall  in  1  decode not ready; hold delivered instruction and PC
redirect_valid  in  1  redirect fields below apply to the current instruction
redirect_type  in  2  00 branch, 01 j/jal, 10 jr, 11 reserved
branch_taken  in  1  branch condition result (used when type=00)
imm16  in  16  branch offset field
imm26  in  26  jump index field
rs_val  in  32  jr target register value
im_req  out  1  fetch request to IM
im_addr  out  32  word address presented to IM
im_ack  in  1  IM has im_instr valid for the current request
im_instr  in  32  instruction word from IM
instr  out  32  captured instruction for decode
instr_valid  out  1  instr is valid
pc  out  32  address of instr
pc_plus4  out  32  pc+4; jal link value
im_timeout  out  1  one-cycle pulse when WAIT_LIMIT expires

Behaviour:
- Reset (async, immediate): pc=RESET_PC, im_req=0, im_addr=RESET_PC, instr=0, instr_valid=0, im_timeout=0, wait counter=0, state=IDLE.
- FSM states: IDLE, REQ, DONE (plus ERR under the optional feature).
- IDLE: transitions to REQ on the first clock after reset is released.
- REQ: im_req=1 and im_addr=pc, both stable until the ack.
  - im_ack is sampled only in REQ.
  - ack=1: capture im_instr into instr, set instr_valid=1, go to DONE. Minimum latency is 1 cycle from REQ entry to instr_valid.
  - ack=0: increment the wait counter.
  - If WAIT_LIMIT>0 and the counter reaches WAIT_LIMIT: pulse im_timeout, drop im_req for one cycle (stay in REQ), clear the counter, then re-assert.
- DONE: im_req=0, instr_valid=1.
  - stall=1: hold everything; redirect inputs are ignored.
  - stall=0: pc<=npc, instr_valid<=0, state<=REQ. Redirect inputs are sampled only on this edge.
- npc:
  - redirect_valid=0: pc+4.
  - type 00: branch_taken ? pc+4+(sext(imm16)<<2) : pc+4.
  - type 01: {pc[31:28], imm26, 2'b00}.
  - type 10: rs_val.
  - type 11: pc+4.
  - All adds wrap modulo 2^32. No delay slot.
- pc_plus4 = pc+4 combinationally, with wrap (32'hFFFF_FFFC -> 0).
- Reset asserted in REQ or DONE: the pending fetch is abandoned, im_req falls in the same cycle, and a late im_ack is ignored.
- stall during REQ/IDLE has no effect.

Optional Feature:
IFU_ALIGN_CHECK_EN
- Defined: an npc with npc[1:0]!=0 is not loaded. pc holds, output fetch_exc (1 bit, added port) goes high sticky, and the state goes to ERR: im_req=0, instr_valid=0. ERR is left only by reset.
- Undefined: npc[1:0] is forced to 2'b00, there is no ERR state and no fetch_exc port.

Decomposition:
- Shared package mips_pkg: redirect_type constants (RT_BRANCH, RT_JUMP, RT_JR, RT_RSVD), default RESET_PC, FSM state encoding.
- One combinational sub-module npc_calc (pc, redirect fields -> npc), reusable by later pipelined IFU.

Test Plan:
- Reset release, IM acks 1 cycle after each req, no redirects -> im_addr sequence 0x3000, 0x3004, 0x3008; instr matches IM words; pc_plus4=0x3004 on the first instr.
- pc=0x3010, branch with imm16=16'hFFFE, taken=1 -> next im_addr 0x300C. Same with taken=0 -> 0x3014.
- pc=0x3010, j with imm26=26'h0000C20 -> im_addr 0x0000_3080. jr with rs_val=0x0000_3040 -> 0x3040.
- stall=1 for 5 cycles in DONE while redirect inputs toggle -> instr, pc and instr_valid unchanged; on stall=0 only the final redirect values apply.
- WAIT_LIMIT=4, IM never acks -> im_timeout pulses every 5th cycle and im_addr stays constant. Reset asserted mid-wait -> im_req=0 in the same cycle, pc=RESET_PC.
- With IFU_ALIGN_CHECK_EN, jr rs_val=0x3042 -> fetch_exc=1, no further im_req until reset. Without the macro -> im_addr 0x3040.
